// File: rtl/alu_issue_ctrl_if.sv
// Instruction, register-load and response channels between the front-end
// (master) and the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [8:0]        instr;
  logic              ld_valid;
  logic              ld_ready;
  logic [2:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_zero;

  modport master (
    output instr_valid, instr, ld_valid, ld_addr, ld_data, res_ready,
    input  instr_ready, ld_ready, res_valid, res_data, res_zero
  );

  modport slave (
    input  instr_valid, instr, ld_valid, ld_addr, ld_data, res_ready,
    output instr_ready, ld_ready, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the 8-bit ALU: owns an 8-entry register
// file, sequences READ/EXEC/RESP per instruction and returns the result.
module alu_issue_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_issue_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_input_a,
  output logic [DATA_W-1:0] alu_input_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              zero,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        instr_q, instr_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [DATA_W-1:0] rf_d [8];
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [2:0]        opc_q, opc_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic [2:0] ra;
  logic [2:0] rb;

  assign ra = instr_q[5:3];
  assign rb = instr_q[2:0];

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rf_d        = rf_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    opc_d       = opc_q;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;

    case (state_q)
      IDLE: begin
        // A load wins over a concurrent instruction; loads to r0 are dropped.
        if (bus.ld_valid) begin
          if (bus.ld_addr != 3'd0) begin
            rf_d[bus.ld_addr] = bus.ld_data;
          end
        end else if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = READ;
        end
      end
      READ: begin
        op_a_d  = (ra == 3'd0) ? '0 : rf_q[ra];
        op_b_d  = (rb == 3'd0) ? '0 : rf_q[rb];
        opc_d   = instr_q[8:6];
        state_d = EXEC;
      end
      EXEC: begin
        res_data_d  = alu_out;
        res_zero_d  = zero;
        res_valid_d = 1'b1;
        if (ra != 3'd0) begin
          rf_d[ra] = alu_out;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (op_count_q != '1) begin
            op_count_d = op_count_q + CNT_W'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opc_q       <= '0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      opc_q       <= opc_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
      for (int unsigned i = 0; i < 8; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign bus.ld_ready    = (state_q == IDLE);
  assign bus.instr_ready = (state_q == IDLE) && !bus.ld_valid;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_zero    = res_zero_q;

  assign alu_input_a = op_a_q;
  assign alu_input_b = op_b_q;
  assign alu_opcode  = opc_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  alu_input_a;
  logic [7:0]  alu_input_b;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic        zero;
  logic [15:0] op_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_cnt   = 0;

  alu_issue_ctrl_if #(.DATA_W(8)) bus ();

  alu_issue_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .alu_input_a (alu_input_a),
    .alu_input_b (alu_input_b),
    .alu_opcode  (alu_opcode),
    .alu_out     (alu_out),
    .zero        (zero),
    .op_count    (op_count)
  );

  // Bench ALU: 001 ADD, 010 XOR, 011 AND; others arbitrary but defined.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_out = alu_input_a;
      3'b001:  alu_out = alu_input_a + alu_input_b;
      3'b010:  alu_out = alu_input_a ^ alu_input_b;
      3'b011:  alu_out = alu_input_a & alu_input_b;
      3'b100:  alu_out = alu_input_a | alu_input_b;
      3'b101:  alu_out = alu_input_a - alu_input_b;
      3'b110:  alu_out = ~alu_input_a;
      default: alu_out = alu_input_b;
    endcase
    zero = (alu_out == 8'h00);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    @(negedge clk);
    bus.ld_valid = 1'b0;
  endtask

  // Issue from IDLE with res_ready high; lat counts negedges after the
  // accepting edge until res_valid is seen (3 == high after edge N+2).
  task automatic run_instr(input logic [8:0] ins, output logic [7:0] d,
                           output logic z, output int lat);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    bus.res_ready   = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = bus.res_data;
    z = bus.res_zero;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b exp 0", bus.res_valid);
    else pass_cnt++;
    total_cnt++;
    if (op_count !== 16'h0000) $display("FAIL rst_op_count: got %h exp 0000", op_count);
    else pass_cnt++;
    total_cnt++;
    if (bus.instr_ready !== 1'b1 || bus.ld_ready !== 1'b1)
      $display("FAIL rst_ready: got instr_ready=%b ld_ready=%b exp 1/1", bus.instr_ready, bus.ld_ready);
    else pass_cnt++;
    total_cnt++;
    if (alu_input_a !== 8'h00 || alu_opcode !== 3'b000)
      $display("FAIL rst_alu_regs: got a=%h opc=%b exp 00/000", alu_input_a, alu_opcode);
    else pass_cnt++;
    #2 reset_n = 1'b1;
  endtask

  task automatic test_basic_add();
    logic [7:0] d;
    logic z;
    int lat;
    do_load(3'd1, 8'h05);
    do_load(3'd2, 8'h03);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 9'b001_001_010;
    bus.res_ready   = 1'b1;
    total_cnt++;
    if (bus.instr_ready !== 1'b1) $display("FAIL add_instr_ready: got %b exp 1", bus.instr_ready);
    else pass_cnt++;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    total_cnt++;
    if (bus.instr_ready !== 1'b0 || bus.ld_ready !== 1'b0)
      $display("FAIL add_read_ready: got instr_ready=%b ld_ready=%b exp 0/0", bus.instr_ready, bus.ld_ready);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (alu_input_a !== 8'h05 || alu_input_b !== 8'h03 || alu_opcode !== 3'b001)
      $display("FAIL add_exec_operands: got a=%h b=%h opc=%b exp 05/03/001", alu_input_a, alu_input_b, alu_opcode);
    else pass_cnt++;
    total_cnt++;
    if (bus.res_valid !== 1'b0) $display("FAIL add_early_valid: got %b exp 0", bus.res_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h08 || bus.res_zero !== 1'b0)
      $display("FAIL add_result: got v=%b d=%h z=%b exp 1/08/0", bus.res_valid, bus.res_data, bus.res_zero);
    else pass_cnt++;
    @(negedge clk);
    exp_cnt++;
    total_cnt++;
    if (op_count !== 16'(exp_cnt) || bus.res_valid !== 1'b0)
      $display("FAIL add_complete: got cnt=%0d v=%b exp %0d/0", op_count, bus.res_valid, exp_cnt);
    else pass_cnt++;
    run_instr(9'b001_001_000, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (lat !== 3 || d !== 8'h08 || z !== 1'b0)
      $display("FAIL add_writeback: got lat=%0d d=%h z=%b exp 3/08/0", lat, d, z);
    else pass_cnt++;
  endtask

  task automatic test_zero_flag();
    logic [7:0] d;
    logic z;
    int lat;
    run_instr(9'b010_010_010, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (lat !== 3 || d !== 8'h00 || z !== 1'b1)
      $display("FAIL xor_zero: got lat=%0d d=%h z=%b exp 3/00/1", lat, d, z);
    else pass_cnt++;
    run_instr(9'b001_010_000, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h00 || z !== 1'b1) $display("FAIL xor_writeback: got d=%h z=%b exp 00/1", d, z);
    else pass_cnt++;
  endtask

  task automatic test_r0();
    logic [7:0] d;
    logic z;
    int lat;
    do_load(3'd0, 8'hFF);
    run_instr(9'b001_000_000, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h00 || z !== 1'b1) $display("FAIL r0_load_ignored: got d=%h z=%b exp 00/1", d, z);
    else pass_cnt++;
    run_instr(9'b001_000_001, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h08 || z !== 1'b0) $display("FAIL r0_dest: got d=%h z=%b exp 08/0", d, z);
    else pass_cnt++;
    run_instr(9'b001_001_000, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h08) $display("FAIL r0_no_write: got d=%h exp 08", d);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 9'b001_001_001;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++;
    if (lat !== 3) $display("FAIL bp_latency: got %0d exp 3", lat);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h10 || alu_input_a !== 8'h08 ||
          alu_input_b !== 8'h08 || bus.instr_ready !== 1'b0 || op_count !== 16'(exp_cnt))
        $display("FAIL bp_stall[%0d]: got v=%b d=%h a=%h b=%h rdy=%b cnt=%0d exp 1/10/08/08/0/%0d",
                 i, bus.res_valid, bus.res_data, alu_input_a, alu_input_b, bus.instr_ready, op_count, exp_cnt);
      else pass_cnt++;
      if (i == 1) begin
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = 3'd4;
        bus.ld_data     = 8'h55;
        bus.instr_valid = 1'b1;
        bus.instr       = 9'b011_111_111;
      end
      @(negedge clk);
    end
    bus.ld_valid    = 1'b0;
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    exp_cnt++;
    total_cnt++;
    if (op_count !== 16'(exp_cnt) || bus.res_valid !== 1'b0 || bus.instr_ready !== 1'b1)
      $display("FAIL bp_release: got cnt=%0d v=%b rdy=%b exp %0d/0/1", op_count, bus.res_valid, bus.instr_ready, exp_cnt);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (op_count !== 16'(exp_cnt)) $display("FAIL bp_single_count: got %0d exp %0d", op_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [7:0] d;
    logic z;
    int lat;
    @(negedge clk);
    bus.ld_valid    = 1'b1;
    bus.ld_addr     = 3'd3;
    bus.ld_data     = 8'h7A;
    bus.instr_valid = 1'b1;
    bus.instr       = 9'b011_011_011;
    bus.res_ready   = 1'b1;
    #1;
    total_cnt++;
    if (bus.instr_ready !== 1'b0 || bus.ld_ready !== 1'b1)
      $display("FAIL coll_ready: got instr_ready=%b ld_ready=%b exp 0/1", bus.instr_ready, bus.ld_ready);
    else pass_cnt++;
    @(negedge clk);
    bus.ld_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.instr_ready !== 1'b1) $display("FAIL coll_instr_next: got %b exp 1", bus.instr_ready);
    else pass_cnt++;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    lat = 1;
    while (!bus.res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++;
    if (lat !== 3 || bus.res_data !== 8'h7A || bus.res_zero !== 1'b0)
      $display("FAIL coll_result: got lat=%0d d=%h z=%b exp 3/7a/0", lat, bus.res_data, bus.res_zero);
    else pass_cnt++;
    @(negedge clk);
    exp_cnt++;
    run_instr(9'b001_100_000, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h00 || z !== 1'b1) $display("FAIL busy_load_ignored: got d=%h z=%b exp 00/1", d, z);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen_d [3];
    int seen_t [3];
    int n = 0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 9'b001_101_011;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (bus.res_valid && n < 3) begin
        seen_d[n] = bus.res_data;
        seen_t[n] = t;
        n++;
      end
    end
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_cnt += 3;
    total_cnt++;
    if (n !== 3) $display("FAIL b2b_count: got %0d responses exp 3", n);
    else pass_cnt++;
    if (n == 3) begin
      total_cnt++;
      if (seen_t[0] !== 3 || seen_t[1] !== 7 || seen_t[2] !== 11)
        $display("FAIL b2b_timing: got %0d,%0d,%0d exp 3,7,11", seen_t[0], seen_t[1], seen_t[2]);
      else pass_cnt++;
      total_cnt++;
      if (seen_d[0] !== 8'h7A || seen_d[1] !== 8'hF4 || seen_d[2] !== 8'h6E)
        $display("FAIL b2b_data: got %h,%h,%h exp 7a,f4,6e", seen_d[0], seen_d[1], seen_d[2]);
      else pass_cnt++;
    end
    total_cnt++;
    if (op_count !== 16'(exp_cnt)) $display("FAIL b2b_op_count: got %0d exp %0d", op_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] d;
    logic z;
    int lat;
    do_load(3'd6, 8'h11);
    bus.res_ready = 1'b0;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 9'b001_110_110;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (alu_input_a !== 8'h11 || alu_input_b !== 8'h11)
      $display("FAIL mid_exec_operands: got a=%h b=%h exp 11/11", alu_input_a, alu_input_b);
    else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.res_valid !== 1'b0 || op_count !== 16'h0000 || alu_input_a !== 8'h00 || bus.instr_ready !== 1'b1)
      $display("FAIL mid_reset_state: got v=%b cnt=%0d a=%h rdy=%b exp 0/0/00/1",
               bus.res_valid, op_count, alu_input_a, bus.instr_ready);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    exp_cnt = 0;
    run_instr(9'b001_110_000, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h00 || z !== 1'b1) $display("FAIL mid_no_writeback: got d=%h z=%b exp 00/1", d, z);
    else pass_cnt++;
    run_instr(9'b001_011_001, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h00) $display("FAIL mid_rf_cleared: got r3+r1=%h exp 00", d);
    else pass_cnt++;
    run_instr(9'b100_101_010, d, z, lat);
    exp_cnt++;
    total_cnt++;
    if (d !== 8'h00 || op_count !== 16'(exp_cnt))
      $display("FAIL mid_after_release: got d=%h cnt=%0d exp 00/%0d", d, op_count, exp_cnt);
    else pass_cnt++;
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.res_ready   = 1'b0;
    test_reset();
    test_basic_add();
    test_zero_flag();
    test_r0();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/sequencing controller that drives the 8-bit ALU.
- It owns an 8-entry, 8-bit register file and accepts 9-bit instructions over a valid/ready handshake.
- For each instruction it reads the operands, drives the ALU operand and opcode inputs, captures the ALU result and zero flag, writes the result back, and returns it over a valid/ready response handshake.
- It sits between the instruction front-end and the combinational ALU; the ALU's `alu_out`/`zero` come back in as inputs.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  controller can accept an instruction this cycle.
- instr  input  9  [8:6] ALU opcode, [5:3] ra (source A and destination), [2:0] rb (source B).
- ld_valid  input  1  register-load request.
- ld_ready  output  1  load can be accepted this cycle.
- ld_addr  input  3  register index to load.
- ld_data  input  DATA_W  load value.
- alu_input_a  output  DATA_W  operand A to the ALU.
- alu_input_b  output  DATA_W  operand B to the ALU.
- alu_opcode  output  3  opcode to the ALU.
- alu_out  input  DATA_W  ALU result (combinational).
- zero  input  1  ALU zero flag.
- res_valid  output  1  response holds a completed result.
- res_ready  input  1  consumer accepts the response.
- res_data  output  DATA_W  captured result.
- res_zero  output  1  captured zero flag.
- op_count  output  CNT_W  number of completed responses; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, `clk`. `reset_n` is asynchronous and active-low. While low, it forces:
  - state = IDLE;
  - all register-file entries = 0;
  - operand/opcode registers, `res_data`, `res_zero`, `res_valid`, `op_count` = 0.
  - Reset asserted mid-operation abandons the instruction; `res_valid` drops immediately; no write-back occurs.
- FSM states: IDLE, READ, EXEC, RESP.
- IDLE:
  - `ld_ready` = 1. `instr_ready` = !ld_valid, so a load has priority over an instruction.
  - On ld_valid: rf[ld_addr] <= ld_data. A load to address 0 is discarded. State stays IDLE.
  - Else on instr_valid && instr_ready: latch instr into instr_q and go to READ.
- READ:
  - op_a_q <= rf[ra], op_b_q <= rf[rb], opc_q <= instr_q[8:6]. Reads of r0 return 0.
  - Go to EXEC.
- EXEC:
  - `alu_input_a`/`alu_input_b`/`alu_opcode` = op_a_q/op_b_q/opc_q. These are registered outputs, held stable from EXEC through RESP and until the next READ.
  - At the clock edge: res_data <= alu_out, res_zero <= zero, rf[ra] <= alu_out (not when ra = 0), res_valid <= 1.
  - Go to RESP.
- RESP:
  - `res_valid` held high; `res_data`/`res_zero` stable until accepted.
  - On res_ready: res_valid <= 0, op_count increments (saturating), go to IDLE.
  - `res_ready` high for several cycles completes only one response.
- Handshake signals:
  - `instr_ready` and `ld_ready` are 0 in READ, EXEC and RESP.
  - `instr_valid`/`ld_valid` asserted outside IDLE are ignored, not queued.
- Latency: instruction accepted at edge N → `res_valid` high after edge N+2. Minimum issue interval is 4 cycles with `res_ready` held high.
- Register-file semantics:
  - Each instruction's write-back is visible to the next instruction's READ (no hazards, single in flight).
  - r0 always reads 0.
- Arithmetic and width: the controller performs no arithmetic on the data. It only routes operands and the result, at DATA_W bits, with no extension.
- Unused opcodes: none. All 8 opcodes are forwarded unchanged.

Test Plan:
- **Basic ADD:** reset; load r1=0x05, r2=0x03; instr {001,001,010} → in EXEC `alu_input_a`=0x05, `alu_input_b`=0x03, `alu_opcode`=001. With the ALU attached: `res_data`=0x08, `res_zero`=0, `res_valid` high 2 cycles after acceptance, and rf[1]=0x08 (confirmed by a following ADD r1,r0 returning 0x08).
- **Zero flag:** with r2=0x03, instr XOR {010,010,010} → `res_data`=0x00, `res_zero`=1, r2 becomes 0x00.
- **r0 hardwiring:**
  - load r0=0xFF → ignored.
  - r1=0x08; instr ADD {001,000,001} → `res_data`=0x08, r0 still reads 0.
  - next instr ADD {001,001,000} with r1 unchanged → 0x08.
- **Backpressure:** hold `res_ready`=0 for 5 cycles after `res_valid` rises → `res_valid`, `res_data` and ALU outputs stable; `instr_ready`=0 throughout; `op_count` unchanged. Then `res_ready`=1 for 1 cycle → `op_count`+1, `instr_ready`=1 the next cycle.
- **Load/instr collision:** in IDLE assert `ld_valid` (r3=0x7A) and `instr_valid` (AND r3,r3) together → load taken, `instr_ready`=0 that cycle. Instr accepted the following cycle, `res_data`=0x7A.
- **Reset mid-op:** pulse `reset_n` low asynchronously during EXEC → `res_valid`=0, state IDLE, `op_count`=0, all registers read 0, and no stale write-back after release.
